// File: rtl/skew_pkg.sv
// Shared constants, lane delay rule and default lane data type for the skew lane buffer.
package skew_pkg;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

  localparam int SKEW_DATA_W = 8;

  typedef logic [SKEW_DATA_W-1:0] lane_data_t;

  // Skew delays lane k by k cycles; deskew mirrors it so the last lane is immediate.
  function automatic int lane_delay(input int k, input logic mode, input int lanes);
    return (mode == MODE_SKEW) ? k : (lanes - 1 - k);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane: a {valid, data} shift register of depth LANES-1 with stall hold and a mode-selected tap.
// Build option SKEW_ZERO_GATE_EN forces bubble data to zero.
module skew_delay_line
  import skew_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = SKEW_DATA_W,
  parameter int LANE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int DEPTH    = LANES - 1;
  localparam int D_SKEW   = lane_delay(LANE, MODE_SKEW, LANES);
  localparam int D_DESKEW = lane_delay(LANE, MODE_DESKEW, LANES);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;
  logic                         tap_valid;
  logic [DATA_W-1:0]            tap_data;
  int                           sel;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (!hold) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // A zero-delay lane bypasses the registers; in_valid is already low while stalled.
  always_comb begin
    sel       = (mode == MODE_SKEW) ? D_SKEW : D_DESKEW;
    tap_valid = in_valid;
    tap_data  = in_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == i + 1) begin
        tap_valid = vld_q[i];
        tap_data  = dat_q[i];
      end
    end
  end

  assign out_valid = tap_valid;
`ifdef SKEW_ZERO_GATE_EN
  assign out_data = tap_valid ? tap_data : '0;
`else
  assign out_data = tap_data;
`endif

endmodule

// File: rtl/skew_lane_buffer.sv
// Skews (mode 0) or deskews (mode 1) a LANES-wide vector, with stall, in-flight count and guarded mode switch.
// Build option SKEW_ZERO_GATE_EN zeroes out_data on lanes without a valid beat.
module skew_lane_buffer
  import skew_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = SKEW_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    stall,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    mode_q,
  output logic                    busy,
  output logic                    mode_err
);

  localparam int CNT_W = $clog2(LANES) + 1;

  logic             accept;
  logic             dec;
  logic             max_lane_valid;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_cur_q, mode_cur_d;

  assign in_ready = rst_n & ~stall;
  assign accept   = in_valid & in_ready;
  assign busy     = (cnt_q != '0);
  assign mode_q   = mode_cur_q;
  assign mode_err = rst_n & (mode != mode_cur_q) & (busy | accept);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_delay_line #(
      .LANES (LANES),
      .DATA_W(DATA_W),
      .LANE  (k)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (stall),
      .in_valid (accept),
      .in_data  (in_data[k*DATA_W +: DATA_W]),
      .mode     (mode_cur_q),
      .out_valid(out_valid[k]),
      .out_data (out_data[k*DATA_W +: DATA_W])
    );
  end

  // A vector is retired when its longest-delay lane emits on a moving cycle.
  assign max_lane_valid = (mode_cur_q == MODE_SKEW) ? out_valid[LANES-1] : out_valid[0];
  assign dec            = max_lane_valid & ~stall;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    mode_cur_d = mode_cur_q;
    if (!busy && !accept) begin
      mode_cur_d = mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mode_cur_q <= MODE_SKEW;
    end else begin
      cnt_q      <= cnt_d;
      mode_cur_q <= mode_cur_d;
    end
  end

endmodule

// File: tb/tb_skew_lane_buffer.sv
// Randomized bench for skew_lane_buffer against a tick-indexed history model of accepted vectors.
module tb_skew_lane_buffer;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int DW = L * W;
  localparam int HN = 8192;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          stall;
  logic [L-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic          mode_q;
  logic          busy;
  logic          mode_err;

  skew_lane_buffer #(.LANES(L), .DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .stall    (stall),
    .out_valid(out_valid),
    .out_data (out_data),
    .mode_q   (mode_q),
    .busy     (busy),
    .mode_err (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: hv/hd[j] is what entered the lanes on the j-th moving cycle; t counts moving cycles.
  logic          hv[HN];
  logic [DW-1:0] hd[HN];
  int            t;
  logic          mode_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (tick %0d)", tag, got, exp, t);
  endtask

  task automatic step(input logic r, input logic iv, input logic [DW-1:0] dat,
                      input logic st, input logic md);
    logic          acc;
    logic          busy_e;
    logic [L-1:0]  ev;
    logic [DW-1:0] ed;
    logic [DW-1:0] msk;
    int            d;
    int            n;
    @(posedge clk);
    #1;
    rst_n    = r;
    in_valid = iv;
    in_data  = dat;
    stall    = st;
    mode     = md;
    @(negedge clk);
    acc = r & ~st & iv;
    n = 0;
    for (int i = 1; i < L; i++) n += int'(hv[t-i]);
    busy_e = (n != 0);
    ev  = '0;
    ed  = '0;
    msk = '0;
    for (int k = 0; k < L; k++) begin
      d = mode_m ? (L - 1 - k) : k;
      if (d == 0) begin
        ev[k] = acc;
        ed[k*W +: W] = dat[k*W +: W];
      end else begin
        ev[k] = hv[t-d];
        ed[k*W +: W] = hd[t-d][k*W +: W];
      end
`ifdef SKEW_ZERO_GATE_EN
      msk[k*W +: W] = '1;
      if (!ev[k]) ed[k*W +: W] = '0;
`else
      msk[k*W +: W] = ev[k] ? {W{1'b1}} : {W{1'b0}};
`endif
    end
    chk("in_ready", 64'(in_ready), 64'(r & ~st));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data & msk), 64'(ed & msk));
    chk("busy", 64'(busy), 64'(busy_e));
    chk("mode_q", 64'(mode_q), 64'(mode_m));
    chk("mode_err", 64'(mode_err), 64'(r & (md != mode_m) & (busy_e | acc)));
    if (!r) begin
      for (int i = 1; i < L; i++) begin
        hv[t-i] = 1'b0;
        hd[t-i] = '0;
      end
      mode_m = 1'b0;
    end else begin
      if (!st) begin
        hv[t] = acc;
        hd[t] = dat;
        t++;
      end
      if (!busy_e && !acc) mode_m = md;
    end
  endtask

  task automatic idle(input int n, input logic md);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, md);
  endtask

  logic          r_r, r_v, r_s, r_m;
  logic [DW-1:0] r_d;

  initial begin
    for (int i = 0; i < HN; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end
    t      = L;
    mode_m = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    stall    = 1'b0;
    mode     = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with in_valid high, then release.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h44332211, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Deskew back-to-back.
    idle(1, 1'b1);
    step(1'b1, 1'b1, 32'h0D0C0B0A, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h1D1C1B1A, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Skew stream with a two-cycle stall.
    idle(1, 1'b0);
    step(1'b1, 1'b1, 32'h04030201, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h14131211, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h24232221, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h24232221, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h24232221, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Mode change requested while busy.
    step(1'b1, 1'b1, 32'h88776655, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h98979695, 1'b0, 1'b1);
    idle(7, 1'b1);
    idle(2, 1'b0);

    // Reset mid-flight with three vectors in flight.
    step(1'b1, 1'b1, 32'hC3C2C1C0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hD3D2D1D0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hE3E2E1E0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hF3F2F1F0, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Random traffic with stalls, mode requests and occasional resets.
    r_m = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r_r = ($urandom_range(0, 99) != 0);
      r_v = ($urandom_range(0, 9) < 6);
      r_s = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) r_m = ~r_m;
      r_d = DW'($urandom);
      step(r_r, r_v, r_d, r_s, r_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
